fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
// - Fetch-stage PC generator feeding the BTB lookup (pc) and consuming its prediction (btb_valid/btb_taken/btb_target).
// - Keeps one prediction record per fetched instruction in a FIFO; compares it at execute resolution.
// - Generates the mispredict redirect/flush and the registered BTB update port (update, update_pc, update_target, mispredicted).
// PARAMETERS
// - RESET_PC   32'h0000_0000  fetch address after reset
// - FIFO_DEPTH 4              max in-flight fetches (fetch..execute); power of two, >=2
// PORTS
// - clk             in   1   clock
// - rst             in   1   synchronous active-high reset
// - stall           in   1   downstream hold; PC and FIFO push frozen
// - btb_valid       in   1   BTB hit for current pc
// - btb_taken       in   1   BTB predicted taken
// - btb_target      in   32  BTB predicted target
// - pc              out  32  current fetch PC (drives BTB pc)
// - fetch_valid     out  1   pc is a real fetch this cycle
// - ex_valid        in   1   one instruction resolves in execute (pops FIFO head)
// - ex_is_branch    in   1   resolved instruction is a control transfer
// - ex_taken        in   1   actual direction
// - ex_target       in   32  actual target
// - flush           out  1   combinational squash of all younger instructions
// - btb_update      out  1   registered BTB write strobe
// - btb_update_pc   out  32  branch PC for update
// - btb_update_target out 32 actual target
// - btb_mispredicted out 1   update caused by a mispredict
// BEHAVIOUR
// - Reset: pc=RESET_PC, FIFO empty, fetch_valid=0 first cycle after reset then 1; flush=0, btb_update=0, btb_update_pc/target=0, btb_mispredicted=0.
// - fetch_valid = !rst & !stall & !fifo_full. Fetch accepted when fetch_valid & !flush.
// - Accepted fetch: push {pc, pred_taken=btb_valid&btb_taken, pred_next = pred_taken ? btb_target : pc+4}; pc <= pred_next next cycle.
// - Not accepted (stall or full), no flush: pc holds.
// - Resolution (ex_valid, FIFO non-empty): pop head; actual_next = (ex_is_branch&ex_taken) ? ex_target : head.pc+4; mispredict = actual_next != head.pred_next.
// - Mispredict in cycle N: flush=1 in N; FIFO cleared at N+1 (cleared wins over same-cycle push/pop); pc=actual_next at N+1, overriding stall; fetch_valid may be 1 at N+1.
// - BTB update registered, visible N+1: btb_update = ex_is_branch & (ex_taken | mispredict); pc=head.pc, target=ex_target, mispredicted=mispredict.
// - Non-branch with false taken hit: redirect/flush only, btb_update=0.
// - Simultaneous push and pop without mispredict: both occur, occupancy unchanged; push allowed when full only if a pop occurs same cycle is NOT supported (full blocks fetch regardless).
// - ex_valid with FIFO empty: ignored (no flush, no update).
// - pc+4 wraps modulo 2^32; pointers wrap modulo FIFO_DEPTH, occupancy counter 0..FIFO_DEPTH.
// - rst mid-operation: all state to reset values next edge, in-flight records discarded, no update issued.
// CONFIGURATION
// - PCGEN_PERF_EN defined: adds outputs perf_branches[31:0], perf_mispredicts[31:0]; increment on resolved branch / any mispredict, reset to 0, wrap at 2^32.
// - Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
// - Package pcgen_pkg: XLEN=32, INSN_BYTES=4, typedef struct pred_entry_t {pc, pred_taken, pred_next}.
// - Sub-module pred_fifo: synchronous FIFO of pred_entry_t with push/pop/clear, full/empty, head output.
// - Top: PC register, next-PC mux (rst > mispredict > stall/full > prediction), compare logic, update register.
// TESTING
// - Reset then no hits: pc 0,4,8,...; FIFO fills to 4 with ex_valid=0 -> fetch_valid=0, pc holds at 16.
// - BTB hit taken at pc=0x10, target 0x80 -> next pc 0x80; ex resolves taken to 0x80 -> no flush, btb_update=1, mispredicted=0.
// - Predicted not-taken at 0x20, ex taken to 0x100 -> flush in N, pc=0x100 and btb_update=1,mispredicted=1,update_pc=0x20 at N+1, FIFO empty.
// - Mispredict with stall=1 and push in same cycle -> pc still redirected, FIFO empty after, pushed entry discarded.
// - False hit on non-branch at 0x40 target 0x200 -> flush, pc=0x44, btb_update=0.
// - PCGEN_PERF_EN: 3 branches, 1 mispredict -> perf_branches=3, perf_mispredicts=1; rst mid-run -> both 0, pc=RESET_PC.

Source files
------------

// File: rtl/pcgen_pkg.sv
// Shared types and constants for the fetch PC generator.
// Optional build macro used by the top: PCGEN_PERF_EN (branch/mispredict counters).
package pcgen_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSN_BYTES = 4;

    // One record per accepted fetch, held until the instruction resolves in execute.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_next;
    } pred_entry_t;

    // Sequential successor of a fetch address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] seq_next(input logic [XLEN-1:0] addr);
        return addr + XLEN'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// Synchronous FIFO of prediction records with push/pop and a squash-all clear.
// Clear wins over a same-cycle push or pop. DEPTH must be a power of two.
module pred_fifo
    import pcgen_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  pred_entry_t push_data,
    input  logic        pop,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    pred_entry_t     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // Status flags, guarded push/pop and head-of-queue read.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        head    = mem_q[rd_ptr_q];
    end

    // Storage array; stale entries are harmless because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: drives the BTB lookup address, records each prediction,
// checks it at execute resolution, redirects on a mispredict and issues a registered
// BTB update. Define PCGEN_PERF_EN to add branch and mispredict counters.
module fetch_pc_gen
    import pcgen_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            btb_valid,
    input  logic            btb_taken,
    input  logic [XLEN-1:0] btb_target,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            flush,
    output logic            btb_update,
    output logic [XLEN-1:0] btb_update_pc,
    output logic [XLEN-1:0] btb_update_target,
    output logic            btb_mispredicted
`ifdef PCGEN_PERF_EN
    ,
    output logic [XLEN-1:0] perf_branches,
    output logic [XLEN-1:0] perf_mispredicts
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    logic            fifo_full;
    logic            fifo_empty;
    pred_entry_t     head;
    pred_entry_t     push_entry;

    logic            pred_taken;
    logic [XLEN-1:0] pred_next;
    logic            accept;

    logic            resolve;
    logic            actual_taken;
    logic [XLEN-1:0] actual_next;
    logic [XLEN-1:0] expected_next;
    logic            mispredict;
    logic            upd_fire;

    logic            upd_q;
    logic [XLEN-1:0] upd_pc_q;
    logic [XLEN-1:0] upd_target_q;
    logic            upd_mis_q;

    pred_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_pred_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (accept),
        .push_data (push_entry),
        .pop       (resolve),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Prediction, resolution compare and next-PC selection (mispredict > hold > predict).
    always_comb begin
        fetch_valid   = ~rst & ~stall & ~fifo_full;

        pred_taken    = btb_valid & btb_taken;
        pred_next     = pred_taken ? btb_target : seq_next(pc_q);

        resolve       = ex_valid & ~fifo_empty;
        actual_taken  = ex_is_branch & ex_taken;
        actual_next   = actual_taken ? ex_target : seq_next(head.pc);
        // A not-taken prediction always meant the sequential address.
        expected_next = head.pred_taken ? head.pred_next : seq_next(head.pc);
        mispredict    = resolve & (actual_next != expected_next);

        flush         = mispredict & ~rst;
        accept        = fetch_valid & ~flush;
        // Non-branches never touch the BTB, even when a false hit caused a redirect.
        upd_fire      = resolve & ex_is_branch & (ex_taken | mispredict);

        push_entry    = '{pc: pc_q, pred_taken: pred_taken, pred_next: pred_next};

        pc_d = pc_q;
        if (mispredict) begin
            pc_d = actual_next;
        end else if (accept) begin
            pc_d = pred_next;
        end

        pc                = pc_q;
        btb_update        = upd_q;
        btb_update_pc     = upd_pc_q;
        btb_update_target = upd_target_q;
        btb_mispredicted  = upd_mis_q;
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB update port, visible the cycle after resolution; address/target hold between updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_q        <= 1'b0;
            upd_pc_q     <= '0;
            upd_target_q <= '0;
            upd_mis_q    <= 1'b0;
        end else begin
            upd_q     <= upd_fire;
            upd_mis_q <= upd_fire & mispredict;
            if (upd_fire) begin
                upd_pc_q     <= head.pc;
                upd_target_q <= ex_target;
            end
        end
    end

`ifdef PCGEN_PERF_EN
    logic [XLEN-1:0] perf_br_q;
    logic [XLEN-1:0] perf_mis_q;

    // Free-running event counters; wrap at 2^XLEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (resolve && ex_is_branch) begin
                perf_br_q <= perf_br_q + XLEN'(1);
            end
            if (mispredict) begin
                perf_mis_q <= perf_mis_q + XLEN'(1);
            end
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_fetch_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        btb_valid;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic        btb_update;
    logic [31:0] btb_update_pc;
    logic [31:0] btb_update_target;
    logic        btb_mispredicted;
`ifdef PCGEN_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    fetch_pc_gen #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .btb_valid         (btb_valid),
        .btb_taken         (btb_taken),
        .btb_target        (btb_target),
        .pc                (pc),
        .fetch_valid       (fetch_valid),
        .ex_valid          (ex_valid),
        .ex_is_branch      (ex_is_branch),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .flush             (flush),
        .btb_update        (btb_update),
        .btb_update_pc     (btb_update_pc),
        .btb_update_target (btb_update_target),
        .btb_mispredicted  (btb_mispredicted)
`ifdef PCGEN_PERF_EN
        ,
        .perf_branches     (perf_branches),
        .perf_mispredicts  (perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pn;   // address the front end went to after this fetch
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_pc;
    logic        m_upd;
    logic [31:0] m_upd_pc;
    logic [31:0] m_upd_tgt;
    logic        m_mis;
    logic [31:0] m_pb;
    logic [31:0] m_pm;

    logic        e_fv;
    logic        e_flush;
    logic        e_res;
    logic        e_mis;
    logic [31:0] e_act;

    task automatic model_reset();
        mq.delete();
        m_pc      = RESET_PC;
        m_upd     = 1'b0;
        m_upd_pc  = '0;
        m_upd_tgt = '0;
        m_mis     = 1'b0;
        m_pb      = '0;
        m_pm      = '0;
    endtask

    // Combinational view of the current cycle, from current inputs and model state.
    task automatic model_eval();
        e_res = ex_valid && (mq.size() > 0);
        e_act = '0;
        e_mis = 1'b0;
        if (e_res) begin
            e_act = (ex_is_branch && ex_taken) ? ex_target : mq[0].pc + 32'd4;
            e_mis = (e_act != mq[0].pn);
        end
        e_fv    = !rst && !stall && (mq.size() < DEPTH);
        e_flush = !rst && e_mis;
    endtask

    // State change at the clock edge.
    task automatic model_commit();
        logic [31:0] pn;
        if (rst) begin
            model_reset();
        end else begin
            m_upd = e_res && ex_is_branch && (ex_taken || e_mis);
            if (m_upd) begin
                m_upd_pc  = mq[0].pc;
                m_upd_tgt = ex_target;
            end
            m_mis = m_upd && e_mis;
            if (e_res && ex_is_branch) m_pb = m_pb + 32'd1;
            if (e_mis) m_pm = m_pm + 32'd1;
            if (e_mis) begin
                mq.delete();
                m_pc = e_act;
            end else begin
                if (e_res) void'(mq.pop_front());
                if (e_fv) begin
                    pn = (btb_valid && btb_taken) ? btb_target : m_pc + 32'd4;
                    mq.push_back('{pc: m_pc, pn: pn});
                    m_pc = pn;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", tag, what, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        bv;
        logic        bt;
        logic [31:0] btgt;
        logic        exv;
        logic        exb;
        logic        ext;
        logic [31:0] extgt;
        logic [31:0] e_pc;
        logic        e_fv;
        logic        e_fl;
        logic        e_upd;
        logic [31:0] e_upc;
        logic [31:0] e_utgt;
        logic        e_mis;
    } vec_t;

    task automatic drive(input logic r, input logic s, input logic bv, input logic bt,
                         input logic [31:0] btgt, input logic exv, input logic exb,
                         input logic ext, input logic [31:0] extgt);
        rst          = r;
        stall        = s;
        btb_valid    = bv;
        btb_taken    = bt;
        btb_target   = btgt;
        ex_valid     = exv;
        ex_is_branch = exb;
        ex_taken     = ext;
        ex_target    = extgt;
    endtask

    // One cycle: inputs already driven while clk is low. Combinational outputs are
    // checked before the edge, registered outputs 1 time unit after it.
    task automatic step(input string tag, input bit use_tbl, input vec_t v);
        #1;
        model_eval();
        if (use_tbl) begin
            chk(tag, "pc", pc, v.e_pc);
            chk(tag, "fetch_valid", {31'd0, fetch_valid}, {31'd0, v.e_fv});
            chk(tag, "flush", {31'd0, flush}, {31'd0, v.e_fl});
        end else begin
            chk(tag, "pc", pc, m_pc);
            chk(tag, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e_fv});
            chk(tag, "flush", {31'd0, flush}, {31'd0, e_flush});
        end
        @(posedge clk);
        model_commit();
        #1;
        if (use_tbl) begin
            chk(tag, "btb_update", {31'd0, btb_update}, {31'd0, v.e_upd});
            chk(tag, "btb_update_pc", btb_update_pc, v.e_upc);
            chk(tag, "btb_update_target", btb_update_target, v.e_utgt);
            chk(tag, "btb_mispredicted", {31'd0, btb_mispredicted}, {31'd0, v.e_mis});
        end else begin
            chk(tag, "btb_update", {31'd0, btb_update}, {31'd0, m_upd});
            chk(tag, "btb_update_pc", btb_update_pc, m_upd_pc);
            chk(tag, "btb_update_target", btb_update_target, m_upd_tgt);
            chk(tag, "btb_mispredicted", {31'd0, btb_mispredicted}, {31'd0, m_mis});
        end
`ifdef PCGEN_PERF_EN
        chk(tag, "perf_branches", perf_branches, m_pb);
        chk(tag, "perf_mispredicts", perf_mispredicts, m_pm);
`endif
        @(negedge clk);
    endtask

    // Step with inputs only; expectations come from the model.
    task automatic mstep(input string tag, input logic r, input logic s, input logic bv,
                         input logic bt, input logic [31:0] btgt, input logic exv,
                         input logic exb, input logic ext, input logic [31:0] extgt);
        vec_t dummy;
        dummy = '{default: '0};
        drive(r, s, bv, bt, btgt, exv, exb, ext, extgt);
        step(tag, 1'b0, dummy);
    endtask

    // Directed vectors starting from a reset cycle; expected values worked out by hand.
    vec_t vecs[25];

    initial begin
        //         rst s  bv bt btgt           exv exb ext extgt          pc             fv fl upd upc           utgt           mis
        vecs[0]  = '{1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,        32'h0,         0};
        vecs[1]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'h0,         1, 0, 0, 32'h0,        32'h0,         0};
        vecs[2]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'h4,         1, 0, 0, 32'h0,        32'h0,         0};
        vecs[3]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'h8,         1, 0, 0, 32'h0,        32'h0,         0};
        vecs[4]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'hC,         1, 0, 0, 32'h0,        32'h0,         0};
        vecs[5]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'h10,        0, 0, 0, 32'h0,        32'h0,         0};
        vecs[6]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'h10,        0, 0, 0, 32'h0,        32'h0,         0};
        vecs[7]  = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,         32'h10,        0, 0, 0, 32'h0,        32'h0,         0};
        vecs[8]  = '{0, 0, 1, 1, 32'h80,       1, 0, 0, 32'h0,         32'h10,        1, 0, 0, 32'h0,        32'h0,         0};
        vecs[9]  = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,         32'h80,        1, 0, 0, 32'h0,        32'h0,         0};
        vecs[10] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,         32'h84,        1, 0, 0, 32'h0,        32'h0,         0};
        vecs[11] = '{0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h80,        32'h88,        1, 0, 1, 32'h10,       32'h80,        0};
        vecs[12] = '{0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h100,       32'h8C,        1, 1, 1, 32'h80,       32'h100,       1};
        vecs[13] = '{0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h123,       32'h100,       1, 0, 0, 32'h80,       32'h100,       0};
        vecs[14] = '{0, 1, 1, 1, 32'h300,      0, 0, 0, 32'h0,         32'h104,       0, 0, 0, 32'h80,       32'h100,       0};
        vecs[15] = '{0, 1, 0, 0, 32'h0,        1, 1, 1, 32'h400,       32'h104,       0, 1, 1, 32'h100,      32'h400,       1};
        vecs[16] = '{0, 0, 1, 0, 32'h999,      0, 0, 0, 32'h0,         32'h400,       1, 0, 0, 32'h100,      32'h400,       0};
        vecs[17] = '{0, 0, 1, 1, 32'h200,      1, 0, 0, 32'h0,         32'h404,       1, 0, 0, 32'h100,      32'h400,       0};
        vecs[18] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,         32'h200,       1, 1, 0, 32'h100,      32'h400,       0};
        vecs[19] = '{0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h777,       32'h408,       1, 0, 0, 32'h100,      32'h400,       0};
        vecs[20] = '{0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h555,       32'h40C,       1, 0, 0, 32'h100,      32'h400,       0};
        vecs[21] = '{0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,         32'h410,       1, 0, 0, 32'h100,      32'h400,       0};
        vecs[22] = '{0, 0, 0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC, 32'h414,       1, 1, 1, 32'h410,      32'hFFFF_FFFC, 1};
        vecs[23] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 32'h410,      32'hFFFF_FFFC, 0};
        vecs[24] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         32'h0,         1, 0, 0, 32'h410,      32'hFFFF_FFFC, 0};
    end

    initial begin
        logic [31:0] rtgt;
        logic [31:0] xtgt;
        logic        r;
        logic        s;
        logic        exb;
        logic        ext;

        drive(1, 0, 0, 0, '0, 0, 0, 0, '0);
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].bv, vecs[i].bt, vecs[i].btgt,
                  vecs[i].exv, vecs[i].exb, vecs[i].ext, vecs[i].extgt);
            step($sformatf("vec%0d", i), 1'b1, vecs[i]);
        end

        // Three branches, one mispredict, then reset with a pending mispredict.
        mstep("seq_rst", 1, 0, 0, 0, '0, 0, 0, 0, '0);
        mstep("seq_f0", 0, 0, 0, 0, '0, 0, 0, 0, '0);
        mstep("seq_f1", 0, 0, 0, 0, '0, 0, 0, 0, '0);
        mstep("seq_f2", 0, 0, 0, 0, '0, 0, 0, 0, '0);
        mstep("seq_b0", 0, 1, 0, 0, '0, 1, 1, 0, '0);
        mstep("seq_b1", 0, 1, 0, 0, '0, 1, 1, 1, 32'h8);
        chk("seq_b1", "btb_update_const", {31'd0, btb_update}, 32'd1);
        mstep("seq_b2", 0, 1, 0, 0, '0, 1, 1, 1, 32'h50);
        chk("seq_b2", "pc_redirect", pc, 32'h50);
        chk("seq_b2", "mispredicted_const", {31'd0, btb_mispredicted}, 32'd1);
`ifdef PCGEN_PERF_EN
        chk("seq_b2", "perf_br_const", perf_branches, 32'd3);
        chk("seq_b2", "perf_mis_const", perf_mispredicts, 32'd1);
`endif
        mstep("seq_f3", 0, 0, 0, 0, '0, 0, 0, 0, '0);
        mstep("seq_midrst", 1, 0, 0, 0, '0, 1, 1, 1, 32'h999);
        chk("seq_midrst", "pc_reset", pc, RESET_PC);
        chk("seq_midrst", "update_reset", {31'd0, btb_update}, 32'd0);
        chk("seq_midrst", "update_pc_reset", btb_update_pc, 32'd0);
`ifdef PCGEN_PERF_EN
        chk("seq_midrst", "perf_br_reset", perf_branches, 32'd0);
        chk("seq_midrst", "perf_mis_reset", perf_mispredicts, 32'd0);
`endif
        // Records fetched before reset must be gone: ex_valid now finds an empty FIFO.
        mstep("seq_post0", 0, 0, 0, 0, '0, 1, 1, 1, 32'h777);
        mstep("seq_post1", 0, 0, 0, 0, '0, 0, 0, 0, '0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 99) == 0);
            s    = ($urandom_range(0, 3) == 0);
            rtgt = $urandom & 32'h0000_0FFC;
            xtgt = $urandom & 32'h0000_0FFC;
            exb  = $urandom_range(0, 1);
            ext  = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                xtgt = mq[0].pn;
                if (mq[0].pn != mq[0].pc + 32'd4) begin
                    exb = 1'b1;
                    ext = 1'b1;
                end
            end
            mstep($sformatf("rand%0d", i), r, s, $urandom_range(0, 1), $urandom_range(0, 1),
                  rtgt, $urandom_range(0, 1), exb, ext, xtgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
